// File: rtl/fg_multichannel_dds.sv
// Multichannel DDS function generator: per-channel prescaled phase accumulators feeding a saturating
// waveform stage, merged round-robin onto one valid/ready stream. Optional macro FG_SYNC_EN adds sync_i.
module fg_multichannel_dds #(
   parameter  int CHANNELS = 4,
   parameter  int BITWIDTH = 8,
   parameter  int ACC_W    = 16,
   parameter  int PSC_W    = 6,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int CFG_W    = 2 + 3*BITWIDTH + ACC_W + PSC_W
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic [CHANNELS*CFG_W-1:0] cfg_i,
`ifdef FG_SYNC_EN
   input  logic                      sync_i,
`endif
   input  logic                      ovr_clr_i,
   output logic [BITWIDTH-1:0]       out_data_o,
   output logic [CH_W-1:0]           out_ch_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [CHANNELS-1:0]       overrun_o
);
   localparam int B = BITWIDTH;

   function automatic logic [B-1:0] wave_f(input logic [1:0] mode, input logic [B-1:0] p,
                                           input logic [B-1:0] duty, input logic [B-1:0] amp);
      logic [B-1:0]   t;
      logic [2*B-1:0] prod;
      t = {p[B-2:0], 1'b0} ^ {B{p[B-1]}};
      prod = {2*B{1'b0}};
      case (mode)
         2'b00: wave_f = amp;
         2'b01: wave_f = (p < duty) ? amp : {B{1'b0}};
         2'b10: begin
            prod   = {{B{1'b0}}, p} * {{B{1'b0}}, amp};
            wave_f = prod[2*B-1:B];
         end
         2'b11: begin
            prod   = {{B{1'b0}}, t} * {{B{1'b0}}, amp};
            wave_f = prod[2*B-1:B];
         end
         default: wave_f = amp;
      endcase
   endfunction

   // Signed offset plus unsigned sample, clamped to the signed B-bit range.
   function automatic logic [B-1:0] sat_f(input logic [B-1:0] off, input logic [B-1:0] s);
      logic [B+1:0] sum;
      sum = {{2{off[B-1]}}, off} + {2'b00, s};
      if (!sum[B+1] && (sum[B:B-1] != 2'b00)) begin
         sat_f = {1'b0, {(B-1){1'b1}}};
      end else if (sum[B+1] && (sum[B:B-1] != 2'b11)) begin
         sat_f = {1'b1, {(B-1){1'b0}}};
      end else begin
         sat_f = sum[B-1:0];
      end
   endfunction

   logic [PSC_W-1:0]    cnt_q   [CHANNELS];
   logic [PSC_W-1:0]    cnt_d   [CHANNELS];
   logic [ACC_W-1:0]    acc_q   [CHANNELS];
   logic [ACC_W-1:0]    acc_d   [CHANNELS];
   logic [B-1:0]        pdata_q [CHANNELS];
   logic [B-1:0]        pdata_d [CHANNELS];
   logic [B-1:0]        y_s     [CHANNELS];
   logic [PSC_W-1:0]    psc_s   [CHANNELS];
   logic [ACC_W-1:0]    inc_s   [CHANNELS];
   logic [CHANNELS-1:0] tick_s, s2_q, pend_q, pend_d, ovr_q, ovr_d, avail_s;
   logic [B-1:0]        out_data_q, out_data_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d, last_q, last_d, grant_s;
   logic                out_valid_q, out_valid_d;
   logic                found_s, load_s, take_s, hit_s, arrive_s, taken_s, sync_s;
   int                  idx_s;

`ifdef FG_SYNC_EN
   assign sync_s = sync_i;
`else
   assign sync_s = 1'b0;
`endif

   // Per-channel prescaler, accumulator and waveform/saturation stage.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         psc_s[c]  = cfg_i[c*CFG_W + 2 + 3*B + ACC_W +: PSC_W];
         inc_s[c]  = cfg_i[c*CFG_W + 2 + 3*B +: ACC_W];
         tick_s[c] = 1'b0;
         cnt_d[c]  = cnt_q[c];
         acc_d[c]  = acc_q[c];
         if (!enable_i || sync_s) begin
            cnt_d[c] = {PSC_W{1'b0}};
            acc_d[c] = {ACC_W{1'b0}};
         end else if (cnt_q[c] == psc_s[c]) begin
            tick_s[c] = 1'b1;
            cnt_d[c]  = {PSC_W{1'b0}};
            acc_d[c]  = acc_q[c] + inc_s[c];
         end else if (cnt_q[c] > psc_s[c]) begin
            cnt_d[c] = {PSC_W{1'b0}};
         end else begin
            cnt_d[c] = cnt_q[c] + PSC_W'(1);
         end
         y_s[c] = sat_f(cfg_i[c*CFG_W + 2 + 2*B +: B],
                        wave_f(cfg_i[c*CFG_W +: 2], acc_q[c][ACC_W-1 -: B],
                               cfg_i[c*CFG_W + 2 +: B], cfg_i[c*CFG_W + 2 + B +: B]));
      end
   end

   // Round-robin arbitration, pending bookkeeping and output register next state.
   always_comb begin
      avail_s = pend_q & {CHANNELS{enable_i}};
      found_s = 1'b0;
      grant_s = {CH_W{1'b0}};
      idx_s   = 0;
      hit_s   = 1'b0;
      for (int i = 1; i <= CHANNELS; i++) begin
         idx_s   = (int'(last_q) + i) % CHANNELS;
         hit_s   = avail_s[idx_s] & ~found_s;
         grant_s = hit_s ? CH_W'(idx_s) : grant_s;
         found_s = found_s | hit_s;
      end
      load_s   = ~out_valid_q | out_ready_i;
      take_s   = load_s & found_s;
      arrive_s = 1'b0;
      taken_s  = 1'b0;
      ovr_d    = ovr_clr_i ? {CHANNELS{1'b0}} : ovr_q;
      for (int c = 0; c < CHANNELS; c++) begin
         arrive_s   = s2_q[c] & enable_i;
         taken_s    = take_s & (grant_s == CH_W'(c));
         pend_d[c]  = enable_i & ((pend_q[c] & ~taken_s) | arrive_s);
         pdata_d[c] = arrive_s ? y_s[c] : pdata_q[c];
         ovr_d[c]   = ovr_d[c] | (arrive_s & pend_q[c] & ~taken_s);
      end
      out_valid_d = load_s ? found_s : out_valid_q;
      out_data_d  = take_s ? pdata_q[grant_s] : out_data_q;
      out_ch_d    = take_s ? grant_s : out_ch_q;
      last_d      = take_s ? grant_s : last_q;
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]   <= {PSC_W{1'b0}};
            acc_q[c]   <= {ACC_W{1'b0}};
            pdata_q[c] <= {B{1'b0}};
         end
         s2_q        <= {CHANNELS{1'b0}};
         pend_q      <= {CHANNELS{1'b0}};
         ovr_q       <= {CHANNELS{1'b0}};
         out_data_q  <= {B{1'b0}};
         out_ch_q    <= {CH_W{1'b0}};
         out_valid_q <= 1'b0;
         last_q      <= CH_W'(CHANNELS - 1);
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]   <= cnt_d[c];
            acc_q[c]   <= acc_d[c];
            pdata_q[c] <= pdata_d[c];
         end
         s2_q        <= tick_s;
         pend_q      <= pend_d;
         ovr_q       <= ovr_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
      end
   end

   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_fg_multichannel_dds.sv
// Directed self-checking bench for fg_multichannel_dds (default parameters); the phase-sync
// scenario is built only when FG_SYNC_EN is defined.
module tb_fg_multichannel_dds;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic [191:0] cfg = '0;
   logic         ovr_clr = 1'b0;
   logic [7:0]   out_data;
   logic [1:0]   out_ch;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [3:0]   overrun;
`ifdef FG_SYNC_EN
   logic         sync = 1'b0;
`endif
   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] mon_ch_q   [$];
   logic [7:0] mon_data_q [$];

   fg_multichannel_dds dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .cfg_i(cfg),
`ifdef FG_SYNC_EN
      .sync_i(sync),
`endif
      .ovr_clr_i(ovr_clr), .out_data_o(out_data), .out_ch_o(out_ch),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   // Record every accepted sample, sampled on the falling edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         mon_ch_q.push_back(out_ch);
         mon_data_q.push_back(out_data);
      end
   end

   function automatic logic [47:0] mk_cfg(input logic [1:0] mode, input logic [7:0] duty,
                                          input logic [7:0] amp, input logic [7:0] off,
                                          input logic [15:0] inc, input logic [5:0] psc);
      return {psc, inc, off, amp, duty, mode};
   endfunction

   function automatic int count_ch(input int ch);
      int n = 0;
      foreach (mon_ch_q[i]) if (int'(mon_ch_q[i]) == ch) n++;
      return n;
   endfunction

   function automatic int nth_ch(input int ch, input int k);
      int n = 0;
      foreach (mon_ch_q[i]) begin
         if (int'(mon_ch_q[i]) == ch) begin
            n++;
            if (n == k) return int'($signed(mon_data_q[i]));
         end
      end
      return 9999;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [47:0] w);
      cfg[c*48 +: 48] = w;
   endtask

   task automatic restart();
      enable = 1'b0;
      rst    = 1'b1;
      for (int c = 0; c < 4; c++) set_ch(c, mk_cfg(2'b00, 8'h00, 8'h00, 8'h00, 16'h0000, 6'd63));
      step(2);
      rst = 1'b0;
      mon_ch_q.delete();
      mon_data_q.delete();
   endtask

   task automatic wait_ch(input int ch, input int n, input int budget, output int got);
      int cyc = 0;
      while (count_ch(ch) < n && cyc < budget) begin
         step(1);
         cyc++;
      end
      got = count_ch(ch);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b0;
      step(2);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
      n_tests++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
      n_tests++; if (overrun !== 4'h0) begin n_fail++; $display("FAIL reset_ovr: got %h want 0", overrun); end
      rst = 1'b0;
      step(6);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_sawtooth();
      int got, p, exp;
      restart();
      set_ch(0, mk_cfg(2'b10, 8'h00, 8'd255, 8'h80, 16'h1000, 6'd0));
      out_ready = 1'b1;
      enable = 1'b1;
      step(2);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid %b want 0", out_valid); end
      step(1);
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || $signed(out_data) !== -8'sd113) begin
         n_fail++; $display("FAIL latency_t3: valid %b ch %0d data %0d want 1 0 -113", out_valid, out_ch, $signed(out_data));
      end
      wait_ch(0, 20, 60, got);
      n_tests++; if (got < 20) begin n_fail++; $display("FAIL saw_count: got %0d want 20", got); end
      for (int k = 1; k <= 20; k++) begin
         p   = (k * 16) & 255;
         exp = -128 + ((p * 255) >> 8);
         n_tests++;
         if (nth_ch(0, k) != exp) begin n_fail++; $display("FAIL saw_%0d: got %0d want %0d", k, nth_ch(0, k), exp); end
      end
   endtask

   task automatic test_square();
      int got;
      int exp_t [8] = '{100, 0, 0, 100, 100, 0, 0, 100};
      restart();
      set_ch(1, mk_cfg(2'b01, 8'h80, 8'd100, 8'h00, 16'h4000, 6'd1));
      out_ready = 1'b1;
      enable = 1'b1;
      wait_ch(1, 8, 40, got);
      n_tests++; if (got < 8) begin n_fail++; $display("FAIL sq_count: got %0d want 8", got); end
      for (int k = 1; k <= 8; k++) begin
         n_tests++;
         if (nth_ch(1, k) != exp_t[k-1]) begin n_fail++; $display("FAIL sq_%0d: got %0d want %0d", k, nth_ch(1, k), exp_t[k-1]); end
      end
   endtask

   task automatic test_round_robin();
      int cyc = 0;
      logic [7:0] held_d;
      logic [1:0] held_c;
      int bad = 0;
      restart();
      for (int c = 0; c < 4; c++) set_ch(c, mk_cfg(2'b00, 8'h00, 8'(c), 8'h00, 16'h0000, 6'd3));
      out_ready = 1'b1;
      enable = 1'b1;
      while (mon_ch_q.size() < 12 && cyc < 40) begin step(1); cyc++; end
      n_tests++; if (mon_ch_q.size() < 12) begin n_fail++; $display("FAIL rr_count: got %0d want 12", mon_ch_q.size()); end
      for (int i = 0; i < 12 && i < mon_ch_q.size(); i++) begin
         n_tests++;
         if (mon_ch_q[i] !== 2'(i % 4) || mon_data_q[i] !== 8'(i % 4)) begin
            n_fail++; $display("FAIL rr_%0d: ch %0d data %0d want %0d", i, mon_ch_q[i], mon_data_q[i], i % 4);
         end
      end
      n_tests++; if (overrun !== 4'h0) begin n_fail++; $display("FAIL rr_no_ovr: got %h want 0", overrun); end
      out_ready = 1'b0;
      step(1);
      held_d = out_data;
      held_c = out_ch;
      n_tests++;
      if (out_valid !== 1'b1 || held_d !== {6'd0, held_c}) begin
         n_fail++; $display("FAIL stall_sample: valid %b data %0d want 1 and %0d", out_valid, held_d, held_c);
      end
      for (int i = 0; i < 9; i++) begin
         step(1);
         if (out_valid !== 1'b1 || out_data !== held_d || out_ch !== held_c) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles want 0", bad); end
      n_tests++; if (overrun !== 4'hF) begin n_fail++; $display("FAIL stall_ovr: got %h want F", overrun); end
      out_ready = 1'b1;
      step(12);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      n_tests++; if (overrun !== 4'h0) begin n_fail++; $display("FAIL ovr_clr: got %h want 0", overrun); end
      step(8);
      n_tests++; if (overrun !== 4'h0) begin n_fail++; $display("FAIL ovr_after: got %h want 0", overrun); end
   endtask

   task automatic test_saturation();
      int got0, got1, got2, p, exp;
      restart();
      set_ch(0, mk_cfg(2'b00, 8'h00, 8'd200, 8'd100, 16'h0000, 6'd63));
      set_ch(1, mk_cfg(2'b00, 8'h00, 8'd0, 8'h80, 16'h0000, 6'd63));
      out_ready = 1'b1;
      enable = 1'b1;
      wait_ch(0, 1, 100, got0);
      wait_ch(1, 1, 20, got1);
      n_tests++; if (got0 < 1 || nth_ch(0, 1) != 127) begin n_fail++; $display("FAIL sat_hi: got %0d want 127", nth_ch(0, 1)); end
      n_tests++; if (got1 < 1 || nth_ch(1, 1) != -128) begin n_fail++; $display("FAIL sat_lo: got %0d want -128", nth_ch(1, 1)); end
      restart();
      set_ch(2, mk_cfg(2'b10, 8'h00, 8'd255, 8'h80, 16'hFFFF, 6'd0));
      enable = 1'b1;
      wait_ch(2, 20, 60, got2);
      n_tests++; if (got2 < 20) begin n_fail++; $display("FAIL wrap_count: got %0d want 20", got2); end
      for (int k = 1; k <= 20; k++) begin
         p   = ((65536 - k) & 16'hFFFF) >> 8;
         exp = -128 + ((p * 255) >> 8);
         n_tests++;
         if (nth_ch(2, k) != exp) begin n_fail++; $display("FAIL wrap_%0d: got %0d want %0d", k, nth_ch(2, k), exp); end
      end
   endtask

`ifdef FG_SYNC_EN
   task automatic test_sync();
      int got0, got1;
      restart();
      set_ch(0, mk_cfg(2'b10, 8'h00, 8'd255, 8'h80, 16'h1000, 6'd3));
      set_ch(1, mk_cfg(2'b10, 8'h00, 8'd255, 8'h80, 16'h3000, 6'd2));
      out_ready = 1'b1;
      enable = 1'b1;
      step(11);
      set_ch(1, mk_cfg(2'b10, 8'h00, 8'd255, 8'h80, 16'h1000, 6'd3));
      step(2);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(8);
      mon_ch_q.delete();
      mon_data_q.delete();
      wait_ch(0, 4, 60, got0);
      wait_ch(1, 4, 20, got1);
      n_tests++; if (got0 < 4 || got1 < 4) begin n_fail++; $display("FAIL sync_count: got %0d/%0d want 4", got0, got1); end
      for (int k = 1; k <= 4; k++) begin
         n_tests++;
         if (nth_ch(0, k) != nth_ch(1, k)) begin n_fail++; $display("FAIL sync_%0d: ch0 %0d ch1 %0d want equal", k, nth_ch(0, k), nth_ch(1, k)); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sawtooth();
      test_square();
      test_round_robin();
      test_saturation();
`ifdef FG_SYNC_EN
      test_sync();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
